apb_mem_slave_p: RTL and testbench
==================================

Name: apb_mem_slave_p

Overview:
Parametrised APB memory slave for peripheral-side register/scratch storage. It generalises the team's 8-bit/16-entry APB slave in data width, depth and wait states, and adds registered responses. It also detects misaligned and out-of-range addresses, and errored writes never modify storage. It sits behind the APB bridge decoder on a single psel line.

Parameters:
ADDR_W, 8, paddr width in bits
DATA_W, 32, data width; legal values 8, 16, 32, 64
DEPTH, 16, number of DATA_W words; ceil(log2(DEPTH)) + log2(DATA_W/8) must be <= ADDR_W
WAIT_STATES, 1, extra access-phase cycles before pready; 0 = zero-wait transfer

Ports:
pclk  in  1  APB clock, all logic on rising edge
presetn  in  1  asynchronous, active-low reset
psel  in  1  slave select
penable  in  1  access phase indicator
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  byte address
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  byte lane strobes (present only with APB_STRB_EN)
prdata  out  DATA_W  read data, registered
pready  out  1  transfer complete, registered
pslverr  out  1  error response, registered; valid only while pready=1

Behaviour:
- Reset (presetn=0, async): state=IDLE, cnt=0, pready=0, pslverr=0, prdata=0. Memory array is not reset; contents are undefined until written.
- Derived values: ALIGN = log2(DATA_W/8). Word index = paddr >> ALIGN.
- Error rules:
  - misaligned: paddr[ALIGN-1:0] != 0 (never set when DATA_W=8)
  - range: word index >= DEPTH
  - err = misaligned | range
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with psel=1 and penable=0 (setup phase), latch paddr, pwrite and err.
  - If WAIT_STATES=0, complete the access (see below) and go to RESP.
  - Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
  - penable=1 seen in IDLE without a preceding setup phase is ignored; no response.
- WAIT:
  - If psel=0, abort: go to IDLE with no memory update and no pready.
  - Otherwise, if cnt=0, complete the access and go to RESP; else decrement cnt.
- Complete access (one edge):
  - Assert pready<=1 and pslverr<=err.
  - Write with !err: mem[idx] <= pwdata, masked by pstrb if enabled. pwdata and pstrb are sampled at this edge.
  - Read with !err: prdata <= mem[idx].
  - Read with err: prdata <= 0.
  - Write with err: memory unchanged; prdata holds its previous value.
- RESP: pready=1 for exactly this one cycle. Next edge: pready<=0, pslverr<=0, state IDLE.
- Latency: access phase lasts WAIT_STATES+1 cycles. Back-to-back transfers require a new setup phase, so the minimum is 2 cycles per transfer.
- Address and pwrite latched at setup are used for the whole transfer; later paddr changes are ignored.
- Reset asserted mid-transfer: FSM returns to IDLE immediately, outputs go to reset values, and a pending write is dropped.
- A write followed by a read of the same address returns the new data.

Optional Feature:
APB_STRB_EN:
- Defined: pstrb port exists. Only byte lanes with pstrb[i]=1 are written. A write with pstrb=0 is legal, completes with pslverr=0 and changes nothing.
- Undefined: no pstrb port; every write updates the full word. Reads are unaffected in both cases.

Test Plan:
1. Defaults, write 0xDEADBEEF to paddr 0x08, then read paddr 0x08 -> pready high in the 2nd access cycle each time, pslverr=0, prdata=0xDEADBEEF.
2. Write paddr 0x40 (word 16 >= DEPTH) with 0x12345678 -> pslverr=1 with pready; read paddr 0x40 -> pslverr=1, prdata=0; words 0-15 unchanged.
3. Read paddr 0x06 (misaligned) -> pslverr=1, prdata=0. Repeat with WAIT_STATES=0 -> pready in 1st access cycle; WAIT_STATES=3 -> pready in 4th.
4. WAIT_STATES=3: write 0xA5A5A5A5 to paddr 0x04, drop psel in 2nd access cycle; read paddr 0x04 -> old value, no pready seen during the aborted write.
5. APB_STRB_EN: word 0x0C holds 0x11223344; write 0xAABBCCDD with pstrb=4'b0101 -> read returns 0x11BB33DD.
6. Assert presetn low during WAIT of a write to 0x00 -> pready=0 and pslverr=0 immediately; after release, a read of 0x00 returns the pre-write value.

Source files
------------

// File: rtl/apb_mem_slave_p.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_slave_p
// Brief    : Parametrised APB memory slave with wait states, registered
//            responses and misaligned/out-of-range error detection.
//            Optional byte-lane strobes via `define APB_STRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_mem_slave_p #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_STRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int c_LANES = DATA_W / 8;
  localparam int c_ALIGN = $clog2(c_LANES);
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [ADDR_W:0]    c_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [c_CNT_W-1:0] cnt_q,     cnt_d;
  logic [c_IDX_W-1:0] idx_q,     idx_d;
  logic               write_q,   write_d;
  logic               err_q,     err_d;
  logic               pready_q,  pready_d;
  logic               pslverr_q, pslverr_d;
  logic [DATA_W-1:0]  prdata_q,  prdata_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [ADDR_W-1:0]  w_word;
  logic               w_misalign;
  logic               w_range;
  logic               w_err;
  logic               w_complete;
  logic               w_acc_write;
  logic               w_acc_err;
  logic [c_IDX_W-1:0] w_acc_idx;
  logic               w_do_wr;
  logic [c_LANES-1:0] w_lane_en;

  assign w_word = paddr >> c_ALIGN;

  generate
    if (c_ALIGN == 0) begin : g_no_align
      assign w_misalign = 1'b0;
    end else begin : g_align
      assign w_misalign = |paddr[c_ALIGN-1:0];
    end
  endgenerate

  assign w_range = {1'b0, w_word} >= c_DEPTH;
  assign w_err   = w_misalign | w_range;

  // With zero wait states the access completes on the setup edge itself,
  // so the live bus values are used instead of the latched copies.
  assign w_acc_write = (state_q == c_IDLE) ? pwrite : write_q;
  assign w_acc_err   = (state_q == c_IDLE) ? w_err : err_q;
  assign w_acc_idx   = (state_q == c_IDLE) ? w_word[c_IDX_W-1:0] : idx_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    err_d      = err_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    w_complete = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (psel && !penable) begin
          idx_d   = w_word[c_IDX_W-1:0];
          write_d = pwrite;
          err_d   = w_err;
          if (WAIT_STATES == 0) begin
            w_complete = 1'b1;
            state_d    = c_RESP;
          end else begin
            cnt_d   = c_CNT_LOAD;
            state_d = c_WAIT;
          end
        end
      end
      c_WAIT: begin
        if (!psel) begin
          state_d = c_IDLE;
        end else if (cnt_q == '0) begin
          w_complete = 1'b1;
          state_d    = c_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      c_RESP: begin
        state_d   = c_IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
      default: state_d = c_IDLE;
    endcase
    if (w_complete) begin
      pready_d  = 1'b1;
      pslverr_d = w_acc_err;
      if (!w_acc_write) begin
        prdata_d = w_acc_err ? '0 : mem_q[w_acc_idx];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= c_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

`ifdef APB_STRB_EN
  assign w_lane_en = pstrb;
`else
  assign w_lane_en = '1;
`endif

  // Storage is not reset; writes are suppressed while reset is held.
  assign w_do_wr = w_complete & w_acc_write & ~w_acc_err & presetn;

  always_ff @(posedge pclk) begin
    if (w_do_wr) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (w_lane_en[i]) begin
          mem_q[w_acc_idx][i*8 +: 8] <= pwdata[i*8 +: 8];
        end
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_mem_slave_p
// Brief    : Scoreboard bench for apb_mem_slave_p; three instances with
//            WAIT_STATES = 1, 0, 3 share one APB bus with separate psel lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave_p;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
`ifdef APB_STRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0] prdata_v  [3];
  logic        pready_v  [3];
  logic        pslverr_v [3];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sbq [3][$];
  logic [31:0] last_prd [3];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    apb_mem_slave_p #(
      .ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(ws_of(k))
    ) u_dut (
      .pclk    (pclk),
      .presetn (presetn),
      .psel    (psel[k]),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_STRB_EN
      .pstrb   (pstrb),
`endif
      .prdata  (prdata_v[k]),
      .pready  (pready_v[k]),
      .pslverr (pslverr_v[k])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pready pulse must match the oldest expectation for that slave.
  always @(negedge pclk) begin
    if (presetn) begin
      for (int k = 0; k < 3; k++) begin
        if (pready_v[k]) begin
          if (sbq[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_pready inst%0d: got pready=1 expected 0 at cycle %0d", k, cyc);
          end else begin
            exp_t e;
            e = sbq[k].pop_front();
            check($sformatf("pslverr inst%0d", k), 32'(pslverr_v[k]), 32'(e.err));
            check($sformatf("prdata inst%0d", k), prdata_v[k], e.rd);
            check($sformatf("latency inst%0d", k), 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit exp_err, input logic [31:0] exp_rd);
    exp_t e;
    bit   seen;
    @(negedge pclk);
    psel    = '0;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
`ifdef APB_STRB_EN
    pstrb   = s;
`endif
    if (!wr) last_prd[k] = exp_err ? 32'h0 : exp_rd;
    e.rd  = last_prd[k];
    e.err = exp_err;
    e.cyc = cyc + 1 + ws_of(k);
    sbq[k].push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge pclk);
      penable = 1'b1;
      paddr   = 8'hFF;   // address and direction must be latched at setup
      pwrite  = ~wr;
      seen    = pready_v[k];
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout inst%0d addr %h: got no pready expected pready", k, a);
    end
    psel    = '0;
    penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
`ifdef APB_STRB_EN
    pstrb   = 4'hF;
`endif
    for (int k = 0; k < 3; k++) last_prd[k] = 32'h0;
    repeat (2) @(negedge pclk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset pready inst%0d", k),  32'(pready_v[k]),  32'h0);
      check($sformatf("reset pslverr inst%0d", k), 32'(pslverr_v[k]), 32'h0);
      check($sformatf("reset prdata inst%0d", k),  prdata_v[k],       32'h0);
    end
    presetn = 1'b1;

    // Basic write/read and the last in-range word
    xfer(0, 1, 8'h08, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    xfer(0, 0, 8'h08, 32'h0,        4'hF, 0, 32'hDEADBEEF);
    xfer(0, 1, 8'h3C, 32'hCAFEF00D, 4'hF, 0, 32'h0);
    xfer(0, 0, 8'h3C, 32'h0,        4'hF, 0, 32'hCAFEF00D);
    xfer(0, 1, 8'h00, 32'h0BADF00D, 4'hF, 0, 32'h0);

    // Out of range: word 16 aliases word 0 in the low index bits
    xfer(0, 1, 8'h40, 32'h12345678, 4'hF, 1, 32'h0);
    xfer(0, 0, 8'h40, 32'h0,        4'hF, 1, 32'h0);
    xfer(0, 0, 8'h00, 32'h0,        4'hF, 0, 32'h0BADF00D);
    xfer(0, 0, 8'h08, 32'h0,        4'hF, 0, 32'hDEADBEEF);

    // Misaligned on all three wait-state settings
    xfer(0, 0, 8'h06, 32'h0,        4'hF, 1, 32'h0);
    xfer(1, 1, 8'h10, 32'h55AA55AA, 4'hF, 0, 32'h0);
    xfer(1, 0, 8'h10, 32'h0,        4'hF, 0, 32'h55AA55AA);
    xfer(1, 0, 8'h06, 32'h0,        4'hF, 1, 32'h0);
    xfer(2, 0, 8'h06, 32'h0,        4'hF, 1, 32'h0);

    // Aborted write: psel dropped in the 2nd access cycle
    xfer(2, 1, 8'h04, 32'h01020304, 4'hF, 0, 32'h0);
    @(negedge pclk);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hA5A5A5A5;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = '0; penable = 1'b0;
    repeat (4) @(negedge pclk);
    xfer(2, 0, 8'h04, 32'h0,        4'hF, 0, 32'h01020304);

    // Asynchronous reset during WAIT of a write
    xfer(2, 1, 8'h00, 32'h600DCAFE, 4'hF, 0, 32'h0);
    xfer(2, 0, 8'h00, 32'h0,        4'hF, 0, 32'h600DCAFE);
    @(negedge pclk);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFFFFFF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("async reset pready",  32'(pready_v[2]),  32'h0);
    check("async reset pslverr", 32'(pslverr_v[2]), 32'h0);
    check("async reset prdata",  prdata_v[2],       32'h0);
    psel = '0; penable = 1'b0;
    for (int k = 0; k < 3; k++) last_prd[k] = 32'h0;
    @(negedge pclk);
    presetn = 1'b1;
    xfer(2, 0, 8'h00, 32'h0,        4'hF, 0, 32'h600DCAFE);

`ifdef APB_STRB_EN
    xfer(0, 1, 8'h0C, 32'h11223344, 4'hF, 0, 32'h0);
    xfer(0, 1, 8'h0C, 32'hAABBCCDD, 4'h5, 0, 32'h0);
    xfer(0, 0, 8'h0C, 32'h0,        4'hF, 0, 32'h11BB33DD);
    xfer(0, 1, 8'h0C, 32'hFFFFFFFF, 4'h0, 0, 32'h0);
    xfer(0, 0, 8'h0C, 32'h0,        4'hF, 0, 32'h11BB33DD);
`endif

    repeat (6) @(negedge pclk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pending responses inst%0d", k), 32'(sbq[k].size()), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
